// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, LSB-first, one bit per enabled clock
// Subtraction is A + ~B + 1, so the carry register is seeded with Sub.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             SerialOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_CMSB = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cmsb;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] sr_next;

    assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    // sr only needs the WIDTH-1 bits already produced; the current bit completes the word
    assign sr_next    = {sum_bit, sr};

    assign Busy      = (state == RUN);
    assign SerialOut = Busy & sum_bit;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            sr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            Done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == IDLE) begin
                if (Start) begin
                    op_a  <= A;
                    op_b  <= Sub ? ~B : B;
                    carry <= Sub;
                    cnt   <= '0;
                    sr    <= '0;
                    cmsb  <= 1'b0;
                    state <= RUN;
                end
            end else if (Enable) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                sr    <= sr_next[WIDTH-1:1];
                carry <= carry_next;
                cnt   <= cnt + 1'b1;
                if (cnt == CNT_CMSB) begin
                    cmsb <= carry_next;
                end
                if (cnt == CNT_LAST) begin
                    S     <= sr_next;
                    Cout  <= carry_next;
                    Ovf   <= cmsb ^ carry_next;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - scoreboard bench for serial_addsub (WIDTH=8 and WIDTH=2 instances)
module tb_serial_addsub;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0, Sub = 1'b0, Enable = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       Busy, Done, Cout, Ovf, SerialOut;
    logic [7:0] S;

    logic       Start2 = 1'b0, Sub2 = 1'b0, Enable2 = 1'b1;
    logic [1:0] A2 = '0, B2 = '0;
    logic       Busy2, Done2, Cout2, Ovf2, SerialOut2;
    logic [1:0] S2;

    always #5 Clock = ~Clock;

    serial_addsub #(.WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub), .Enable(Enable),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .S(S), .Cout(Cout), .Ovf(Ovf),
        .SerialOut(SerialOut)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Start(Start2), .Sub(Sub2), .Enable(Enable2),
        .A(A2), .B(B2), .Busy(Busy2), .Done(Done2), .S(S2), .Cout(Cout2), .Ovf(Ovf2),
        .SerialOut(SerialOut2)
    );

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        longint m, h, ua, ub, sa, sb, r;
        exp_t e;
        m  = longint'(1) << w;
        h  = m / 2;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        r  = sub ? sa - sb : sa + sb;
        e.s    = 32'((sub ? ua - ub : ua + ub) & (m - 1));
        e.cout = sub ? (ua >= ub) : ((ua + ub) >= m);
        e.ovf  = (r >= h) || (r < -h);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor for the 8-bit instance: result, latency, pulse width and serial bit stream
    initial begin : mon8
        logic [7:0] ser;
        logic [7:0] last_s;
        int         nser;
        logic       done_prev;
        exp_t       e;
        ser = '0; last_s = '0; nser = 0; done_prev = 1'b0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                nser = 0; last_s = '0; done_prev = 1'b0;
            end else begin
                if (Busy) chk("s_hold", S, last_s);
                else      chk("serial_idle", SerialOut, 0);
                if (Busy && Enable) begin
                    if (nser < 8) ser[nser] = SerialOut;
                    nser++;
                end
                if (Done) begin
                    chk("done_width", done_prev, 0);
                    if (q8.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q8.pop_front();
                        chk("s", S, e.s[7:0]);
                        chk("cout", Cout, e.cout);
                        chk("ovf", Ovf, e.ovf);
                        chk("done_cycle", cyc, e.cyc);
                        chk("serial_bits", ser, e.s[7:0]);
                        chk("serial_count", nser, 8);
                    end
                    last_s = S;
                    nser = 0;
                end
                done_prev = Done;
            end
        end
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge Clock);
            if (!Reset && Done2) begin
                if (q2.size() == 0) begin
                    chk("w2_unexpected_done", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("w2_s", S2, e.s[1:0]);
                    chk("w2_cout", Cout2, e.cout);
                    chk("w2_ovf", Ovf2, e.ovf);
                    chk("w2_done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issues one 8-bit operation; returns at #1 after the Done edge so the next call
    // drives Start in the Done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input int st_at, input int st_n, input int bogus_at);
        exp_t e;
        int   t;
        e = model(8, a, b, sub);
        e.cyc = cyc + 1 + 8 + st_n;
        q8.push_back(e);
        A = a; B = b; Sub = sub; Start = 1'b1; Enable = 1'($urandom_range(0, 1));
        @(posedge Clock); #1;
        Start = 1'b0; A = 8'($urandom); B = 8'($urandom); Sub = ~sub;
        t = 0;
        while (!Done && t < 64) begin
            Enable = !(t >= st_at && t < st_at + st_n);
            Start  = (t == bogus_at);
            if (Start) A = 8'h00;
            @(posedge Clock); #1;
            t++;
        end
        Start = 1'b0; Enable = 1'b1;
        if (!Done) chk("done_timeout", 0, 1);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic sub);
        exp_t e;
        int   t;
        e = model(2, {30'd0, a}, {30'd0, b}, sub);
        e.cyc = cyc + 1 + 2;
        q2.push_back(e);
        A2 = a; B2 = b; Sub2 = sub; Start2 = 1'b1;
        @(posedge Clock); #1;
        Start2 = 1'b0;
        t = 0;
        while (!Done2 && t < 16) begin
            @(posedge Clock); #1;
            t++;
        end
        if (!Done2) chk("w2_done_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_s", S, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_ovf", Ovf, 0);
        chk("rst_serial", SerialOut, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        op8(8'h3C, 8'h55, 1'b0, -1, 0, -1);
        op8(8'hFF, 8'h01, 1'b0, -1, 0, -1);
        op8(8'h10, 8'h20, 1'b1, -1, 0, -1);
        op8(8'h80, 8'h01, 1'b1, -1, 0, 3);
        op8(8'h3C, 8'h55, 1'b0, 4, 3, -1);

        // Abort mid-RUN with an asynchronous reset between clock edges
        A = 8'h3C; B = 8'h55; Sub = 1'b0; Start = 1'b1; Enable = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_s", S, 0);
        chk("abort_cout", Cout, 0);
        chk("abort_ovf", Ovf, 0);
        chk("abort_done", Done, 0);
        @(negedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b0;
        op8(8'h01, 8'h01, 1'b0, -1, 0, -1);

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        op2(2'b01, 2'b01, 1'b0);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int s = 0; s < 2; s++)
                    op2(2'(a), 2'(b), 1'(s));

        repeat (4) @(posedge Clock);
        #1;
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
